// File: rtl/mem_rd_pkg.sv
// rtl/mem_rd_pkg.sv - shared constants, FSM state encoding and length saturation for the burst reader
package mem_rd_pkg;

    localparam int ADDR_W     = 3;
    localparam int DATA_W     = 4;
    localparam int MEM_DEPTH  = 8;
    localparam int FIFO_DEPTH = 2;

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(MEM_DEPTH);

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t READ  = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t FIN   = 2'd3;

    // A burst never reads more than one full pass over the memory.
    function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

endpackage

// File: rtl/mem_rd_fifo2.sv
// rtl/mem_rd_fifo2.sv - two-entry synchronous FIFO with push/pop/full/empty
module mem_rd_fifo2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             wr_sel;
    logic             rd_sel;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign dout  = rd_sel ? slot1 : slot0;

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0  <= '0;
            slot1  <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_sel) begin
                    slot1 <= din;
                end else begin
                    slot0 <= din;
                end
                wr_sel <= ~wr_sel;
            end
            if (do_pop) begin
                rd_sel <= ~rd_sel;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem8x4_burst_reader.sv
// rtl/mem8x4_burst_reader.sv - burst read initiator for the 8x4 memory, optional m_last under MEM_RD_LAST_EN
module mem8x4_burst_reader
    import mem_rd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
`ifdef MEM_RD_LAST_EN
    output logic              m_last,
`endif
    input  logic              m_ready
);

`ifdef MEM_RD_LAST_EN
    localparam int FIFO_W = DATA_W + 1;
`else
    localparam int FIFO_W = DATA_W;
`endif

    state_t            state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   remaining;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              issue;
    logic [FIFO_W-1:0] fifo_din;
    logic [FIFO_W-1:0] fifo_dout;

    assign busy        = (state == READ) || (state == DRAIN);
    assign done        = (state == FIN);
    assign mem_addr    = rd_ptr;
    assign mem_wr      = 1'b0;
    assign mem_data_in = '0;

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;
    assign issue   = (state == READ) && (remaining != '0) && (!fifo_full || pop);

`ifdef MEM_RD_LAST_EN
    // The flag rides with the word so it stays aligned through backpressure.
    assign fifo_din = {remaining == (ADDR_W + 1)'(1), mem_data_out};
    assign m_data   = fifo_dout[DATA_W-1:0];
    assign m_last   = m_valid && fifo_dout[DATA_W];
`else
    assign fifo_din = mem_data_out;
    assign m_data   = fifo_dout;
`endif

    mem_rd_fifo2 #(
        .WIDTH(FIFO_W)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (issue),
        .pop  (pop),
        .din  (fifo_din),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            rd_ptr    <= start_addr;
                            remaining <= sat_len(len);
                            state     <= READ;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_ptr    <= rd_ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == (ADDR_W + 1)'(1)) begin
                            state <= DRAIN;
                        end
                    end else if (remaining == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state <= FIN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem8x4_burst_reader.sv
// tb/tb_mem8x4_burst_reader.sv - self-checking bench for mem8x4_burst_reader
module tb_mem8x4_burst_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] start_addr;
    logic [3:0] len;
    logic       busy;
    logic       done;
    logic [2:0] mem_addr;
    logic       mem_wr;
    logic [3:0] mem_data_in;
    logic [3:0] mem_data_out;
    logic [3:0] m_data;
    logic       m_valid;
    logic       m_ready;
`ifdef MEM_RD_LAST_EN
    logic       m_last;
`endif

    logic [3:0] mem [8];

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    int exp_q[$];
    int got[$];
    int addr_q[$];
    int hs_cyc[$];
    int issued;
    int popped;
    int done_cnt;
    int start_cyc;

    logic       prev_busy;
    logic       prev_stall;
    logic       prev_done;
    logic [2:0] prev_addr;
    logic [3:0] prev_data;
    int         occ;

    assign mem_data_out = mem[mem_addr];

    mem8x4_burst_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_wr      (mem_wr),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out),
        .m_data      (m_data),
        .m_valid     (m_valid),
`ifdef MEM_RD_LAST_EN
        .m_last      (m_last),
`endif
        .m_ready     (m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy  = 1'b0;
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            chk("mem_write_idle", {mem_wr, mem_data_in}, 0);
            if (prev_busy && busy && mem_addr != prev_addr) begin
                issued++;
                addr_q.push_back(prev_addr);
                chk("addr_step", mem_addr, (prev_addr + 1) % 8);
            end
            occ = issued - popped;
            chk("reads_ahead_le2", occ <= 2, 1);
            chk("valid_vs_buffered", m_valid, occ > 0);
            if (prev_stall) chk("stall_hold", {m_valid, m_data}, {1'b1, prev_data});
            if (m_valid) begin
                if (exp_q.size() == 0) chk("extra_word", 1, 0);
                else begin
                    chk("m_data", m_data, exp_q[0]);
`ifdef MEM_RD_LAST_EN
                    chk("m_last", m_last, exp_q.size() == 1);
`endif
                end
            end
`ifdef MEM_RD_LAST_EN
            else chk("m_last_idle", m_last, 0);
`endif
            if (done) begin
                done_cnt++;
                chk("busy_low_at_done", busy, 0);
            end
            if (prev_done) chk("done_one_cycle", done, 0);
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                hs_cyc.push_back(cyc);
                popped++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_busy  = busy;
            prev_addr  = mem_addr;
            prev_done  = done;
        end
    end

    function automatic logic rdy(input int mode, input int c);
        return (mode == 0) || (c % 3 == 0);
    endfunction

    task automatic setup_model(input int sa, input int ln);
        int n;
        n = (ln > 8) ? 8 : ln;
        exp_q.delete();
        got.delete();
        addr_q.delete();
        hs_cyc.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(mem[(sa + i) % 8]);
        issued   = 0;
        popped   = 0;
        done_cnt = 0;
    endtask

    task automatic run_burst(input int sa, input int ln, input int rmode, input bit hold);
        int n;
        bit seen;
        n = (ln > 8) ? 8 : ln;
        setup_model(sa, ln);
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = 3'(sa);
        len        = 4'(ln);
        m_ready    = rdy(rmode, 0);
        start_cyc  = cyc;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        if (n > 0) begin
            chk("busy_after_start", busy, 1);
            chk("first_addr", mem_addr, sa);
        end
        seen = done;
        for (int c = 1; c < 200 && !seen; c++) begin
            m_ready = rdy(rmode, c);
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_cnt, 1);
        chk("word_count", got.size(), n);
        chk("reads_issued", issued, n);
        if (n > 0 && rmode == 0) begin
            chk("first_word_latency", hs_cyc[0] - start_cyc, 2);
            chk("throughput", hs_cyc[n-1] - hs_cyc[0], n - 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 4'(8 + i);
        rst_n = 1'b0; start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b1;
        issued = 0; popped = 0; done_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", m_data, 0);
        rst_n = 1'b1;

        run_burst(2, 4, 0, 0);
        chk("t1_w0", got[0], 4'hA);
        chk("t1_w3", got[3], 4'hD);
        chk("t1_a0", addr_q[0], 2);
        chk("t1_a3", addr_q[3], 5);

        run_burst(6, 4, 0, 0);
        chk("wrap_w0", got[0], 4'hE);
        chk("wrap_w1", got[1], 4'hF);
        chk("wrap_w2", got[2], 4'h8);
        chk("wrap_w3", got[3], 4'h9);
        chk("wrap_a1", addr_q[1], 7);
        chk("wrap_a2", addr_q[2], 0);

        run_burst(1, 8, 1, 0);
        chk("bp_first", got[0], 4'h9);
        chk("bp_last", got[7], 4'h8);

        run_burst(3, 0, 0, 0);
        chk("len0_done_latency", cyc - start_cyc, 4);

        run_burst(5, 12, 0, 0);
        chk("sat_last", got[7], 4'hC);

        run_burst(0, 3, 0, 1);
        chk("hold_w2", got[2], 4'hA);
        run_burst(4, 2, 0, 0);
        chk("after_hold_w0", got[0], 4'hC);

        setup_model(0, 8);
        @(posedge clk); #1;
        start = 1'b1; start_addr = 3'd0; len = 4'd8; m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("prefill_valid", m_valid, 1);
        chk("prefill_reads", issued, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        issued = 0; popped = 0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);

        run_burst(7, 2, 0, 0);
        chk("post_rst_w0", got[0], 4'hF);
        chk("post_rst_w1", got[1], 4'h8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem8x4_burst_reader.md
Name: mem8x4_burst_reader

Overview:
- Read-side initiator for the 8x4 memory block.
- Accepts a start address and a word count. Issues sequential reads on the memory port with wrap-around at the top address.
- Streams the returned words out through a valid/ready interface, buffered by a 2-entry FIFO for full throughput.
- Sits between the memory and any consumer, e.g. a UART TX or display driver.

Parameters:
- ADDR_W, 3, memory address width; depth = 2**ADDR_W = 8.
- DATA_W, 4, memory word width.
- FIFO_DEPTH, 2, output buffer entries; fixed at 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- start_addr  input  ADDR_W  first address of the burst.
- len  input  ADDR_W+1  word count; 0 means no-op, values >8 saturate to 8.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse at burst end.
- mem_addr  output  ADDR_W  memory address.
- mem_wr  output  1  memory write enable; constant 0.
- mem_data_in  output  DATA_W  memory write data; constant 0.
- mem_data_out  input  DATA_W  memory read data; combinational read of mem_addr.
- m_data  output  DATA_W  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready.

Behaviour:
- Reset (async, rst_n=0), all registers cleared: busy=0, done=0, mem_addr=0, m_valid=0, m_data=0, FIFO empty, FSM=IDLE.
- Reset mid-burst aborts the burst immediately. No done pulse.
- IDLE:
  - start=1 with len!=0: latch rd_ptr=start_addr and remaining=min(len,8); busy=1; go to READ.
  - start=1 with len=0: go to FIN with no memory reads.
- READ:
  - mem_addr = rd_ptr every cycle.
  - Issue condition: remaining!=0 and FIFO not full, or FIFO full and pop this cycle.
  - On issue: at the clock edge push mem_data_out into the FIFO, rd_ptr = rd_ptr+1 mod 8 (7 wraps to 0), remaining -= 1.
  - When remaining reaches 0, go to DRAIN.
- DRAIN: wait until the FIFO is empty, i.e. the last m_valid&&m_ready handshake has occurred, then go to FIN.
- FIN: done=1 for exactly one cycle; busy=0 in the same cycle; go to IDLE.
- Read latency: the first word appears on m_valid 2 cycles after start (start edge, then read edge).
- Throughput: 1 word/cycle while m_ready=1.
- Stream rules:
  - m_valid=1 exactly when the FIFO is non-empty; m_data = FIFO head.
  - When m_valid=1 and m_ready=0, m_data holds stable and m_valid stays 1.
  - Words leave in address order.
- Simultaneous push and pop on a full FIFO is allowed; count is unchanged.
- start while busy=1 or in FIN is ignored.
- mem_wr and mem_data_in are never driven non-zero.

Optional Feature:
- Macro: MEM_RD_LAST_EN.
- Defined: adds output port m_last (1 bit), high with the final word of the burst while m_valid=1, else 0. A 1-bit flag is stored per FIFO entry.
- Undefined: no m_last port and no extra storage.

Decomposition:
- Package mem_rd_pkg holds:
  - ADDR_W and DATA_W constants.
  - MEM_DEPTH = 8.
  - FSM state typedef with values IDLE, READ, DRAIN, FIN.
- Sub-module mem_rd_fifo2: a 2-entry synchronous FIFO with push/pop/full/empty and async active-low reset. The top-level block owns the FSM, address pointer and counter.

Test Plan:
- Preload mem[0..7]=8,9,A,B,C,D,E,F; start_addr=2, len=4, m_ready=1 -> m_data sequence A,B,C,D on consecutive cycles; mem_addr sequence 2,3,4,5; done pulses once; busy falls with done.
- Wrap-around: start_addr=6, len=4 -> mem_addr 6,7,0,1; data E,F,8,9.
- Backpressure: len=8, m_ready toggles 1,0,0,1,... -> no word lost or duplicated; m_data stable while stalled; at most 2 reads ahead of the consumer.
- len=0 -> no m_valid; done pulse one cycle after start; len=12 -> exactly 8 words.
- start held high during a burst -> ignored; the second burst is accepted only after done.
- Assert rst_n=0 mid-burst with 2 words buffered -> m_valid=0 and busy=0 immediately; no done pulse; a new burst after reset works normally. With MEM_RD_LAST_EN defined, m_last=1 only on the final word of each burst.
